input_loop: RTL and testbench



---
 rtl/cnn_pkg.sv | 27 ++
 rtl/input_loop_adder_tree.sv | 20 ++
 rtl/input_loop.sv | 94 +++++++++
 tb/tb_input_loop.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and fixed-point helpers for the CNN convolution accelerator.
// sat_narrow clamps a wide signed value into a narrower signed range.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;
  localparam int WIDE_W     = 128;

  typedef logic signed [DATA_W_DEF-1:0] data_t;
  typedef logic signed [WIDE_W-1:0]     wide_t;

  // Result is already clamped; the caller keeps the low w bits.
  function automatic wide_t sat_narrow(input wide_t x, input int w);
    wide_t maxv;
    wide_t minv;
    maxv = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    minv = ~maxv;
    if (x > maxv) begin
      return maxv;
    end else if (x < minv) begin
      return minv;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/input_loop_adder_tree.sv
// Combinational signed reduction of LEAVES product terms plus one init term.
// SUM_W must leave enough headroom that no partial sum can overflow.
module input_loop_adder_tree #(
  parameter int LEAVES = 1,
  parameter int LEAF_W = 32,
  parameter int SUM_W  = LEAF_W + $clog2(LEAVES + 1)
) (
  input  logic signed [LEAF_W-1:0] i_leaf [LEAVES],
  input  logic signed [LEAF_W-1:0] i_init,
  output logic signed [SUM_W-1:0]  o_sum
);

  always_comb begin
    o_sum = SUM_W'(i_init);
    for (int n = 0; n < LEAVES; n++) begin
      o_sum = o_sum + SUM_W'(i_leaf[n]);
    end
  end

endmodule

// File: rtl/input_loop.sv
// Two-stage fixed-point inner product: fm_o = fm_init_i + sum(fm_i[n] * weights_i[n]).
// Define INPUT_LOOP_SAT_EN to saturate the result instead of wrapping it.
module input_loop
  import cnn_pkg::*;
#(
  parameter int Tn_p   = 1,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] fm_i      [Tn_p],
  input  logic signed [DATA_W-1:0] weights_i [Tn_p],
  input  logic signed [DATA_W-1:0] fm_init_i,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] fm_o
);

  localparam int PROD_W  = 2 * DATA_W;
  localparam int SUM_W   = PROD_W + $clog2(Tn_p + 1);
  localparam int SHIFT_W = SUM_W - FRAC_W;

  logic signed [PROD_W-1:0]  r_prod [Tn_p];
  logic signed [DATA_W-1:0]  r_init;
  logic                      r_v1;
  logic                      r_valid_o;
  logic signed [DATA_W-1:0]  r_fm_o;

  logic signed [PROD_W-1:0]  w_init_term;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [SHIFT_W-1:0] w_shifted;
  logic signed [DATA_W-1:0]  w_narrow;
  logic                      w_unused;

  // Stage 1: full-precision products; operands are only captured when valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v1   <= 1'b0;
      r_init <= '0;
      for (int n = 0; n < Tn_p; n++) begin
        r_prod[n] <= '0;
      end
    end else begin
      r_v1 <= valid_i;
      if (valid_i) begin
        r_init <= fm_init_i;
        for (int n = 0; n < Tn_p; n++) begin
          r_prod[n] <= PROD_W'(fm_i[n]) * PROD_W'(weights_i[n]);
        end
      end
    end
  end

  // Align the init word to the products' Q.2*FRAC_W scale.
  assign w_init_term = PROD_W'(r_init) <<< FRAC_W;

  input_loop_adder_tree #(
    .LEAVES (Tn_p),
    .LEAF_W (PROD_W),
    .SUM_W  (SUM_W)
  ) u_adder_tree (
    .i_leaf (r_prod),
    .i_init (w_init_term),
    .o_sum  (w_sum)
  );

  // Dropping the low FRAC_W bits is an arithmetic shift, i.e. floor rounding.
  assign w_shifted = w_sum[SUM_W-1:FRAC_W];

`ifdef INPUT_LOOP_SAT_EN
  assign w_narrow = DATA_W'(sat_narrow(WIDE_W'(w_shifted), DATA_W));
  assign w_unused = ^w_sum[FRAC_W-1:0];
`else
  assign w_narrow = w_shifted[DATA_W-1:0];
  assign w_unused = ^{w_sum[FRAC_W-1:0], w_shifted[SHIFT_W-1:DATA_W]};
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid_o <= 1'b0;
      r_fm_o    <= '0;
    end else begin
      r_valid_o <= r_v1;
      if (r_v1) begin
        r_fm_o <= w_narrow;
      end
    end
  end

  assign valid_o = r_valid_o;
  assign fm_o    = r_fm_o;

endmodule

// File: tb/tb_input_loop.sv
// Self-checking bench for input_loop (Tn_p=3, Q8.8) against a behavioural model.
// Honours INPUT_LOOP_SAT_EN the same way the design does.
module tb_input_loop;
  import cnn_pkg::*;

  localparam int TN     = 3;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef data_t vec3_t [TN];

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  valid_i = 1'b0;
  vec3_t fm_i = '{default: '0};
  vec3_t weights_i = '{default: '0};
  data_t fm_init_i = '0;
  logic  valid_o;
  data_t fm_o;

  int    nChecks = 0;
  int    nPass = 0;
  data_t expFm = '0;

  always #5 clk = ~clk;

  input_loop #(.Tn_p(TN), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .valid_i   (valid_i),
    .fm_i      (fm_i),
    .weights_i (weights_i),
    .fm_init_i (fm_init_i),
    .valid_o   (valid_o),
    .fm_o      (fm_o)
  );

  // Reference: exact integer inner product, floor divide by 2^FRAC_W, then narrow.
  function automatic data_t model(input vec3_t f, input vec3_t w, input data_t init);
    longint acc;
    acc = longint'(init) * (longint'(1) << FRAC_W);
    for (int n = 0; n < TN; n++) acc += longint'(f[n]) * longint'(w[n]);
    acc = acc >>> FRAC_W;
`ifdef INPUT_LOOP_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return data_t'(acc);
  endfunction

  function automatic vec3_t mk(input data_t a, input data_t b, input data_t c);
    vec3_t v;
    v[0] = a; v[1] = b; v[2] = c;
    return v;
  endfunction

  function automatic vec3_t randVec();
    vec3_t v;
    for (int n = 0; n < TN; n++) v[n] = data_t'($urandom);
    return v;
  endfunction

  // Present one cycle of operands, then step to just after the sampling edge.
  task automatic drive(input logic v, input vec3_t f, input vec3_t w, input data_t init);
    valid_i = v;
    fm_i = f;
    weights_i = w;
    fm_init_i = init;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, randVec(), randVec(), data_t'($urandom));
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    nChecks++;
    if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid_o);
    else nPass++;
    nChecks++;
    if (fm_o !== 16'h0000) $display("[TB] FAIL reset_fm: got %h expected 0000", fm_o);
    else nPass++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();
    nChecks++;
    if (valid_o !== 1'b0) $display("[TB] FAIL post_reset_valid: got %b expected 0", valid_o);
    else nPass++;
    expFm = '0;
  endtask

  task automatic test_basic();
    drive(1'b1, mk(16'h0740, 16'h0500, 16'h1400), mk(16'h0100, 16'h0000, 16'h0000), 16'h0A80);
    nChecks++;
    if (valid_o !== 1'b0) $display("[TB] FAIL basic_latency1: got %b expected 0", valid_o);
    else nPass++;
    idle();
    nChecks++;
    if (valid_o !== 1'b1) $display("[TB] FAIL basic_latency2: got %b expected 1", valid_o);
    else nPass++;
    nChecks++;
    if (fm_o !== 16'h11C0) $display("[TB] FAIL basic_value: got %h expected 11c0", fm_o);
    else nPass++;
    idle();
    nChecks++;
    if (valid_o !== 1'b0) $display("[TB] FAIL basic_pulse: got %b expected 0", valid_o);
    else nPass++;
    nChecks++;
    if (fm_o !== 16'h11C0) $display("[TB] FAIL basic_hold: got %h expected 11c0", fm_o);
    else nPass++;
    expFm = 16'h11C0;
  endtask

  task automatic test_zero_and_mixed();
    drive(1'b1, mk(16'h0740, 16'h0500, 16'h1400), mk(16'h0000, 16'h0000, 16'h0000), 16'h0000);
    drive(1'b1, mk(16'h0740, 16'h0500, 16'h1400), mk(16'h0080, 16'hFF00, 16'h0040), 16'hFE00);
    nChecks++;
    if (valid_o !== 1'b1 || fm_o !== 16'h0000)
      $display("[TB] FAIL zero_weights: got v=%b fm=%h expected v=1 fm=0000", valid_o, fm_o);
    else nPass++;
    idle();
    nChecks++;
    if (valid_o !== 1'b1 || fm_o !== 16'h01A0)
      $display("[TB] FAIL mixed_weights: got v=%b fm=%h expected v=1 fm=01a0", valid_o, fm_o);
    else nPass++;
    idle();
    expFm = 16'h01A0;
  endtask

  task automatic test_overflow();
    data_t expPos;
    data_t expNeg;
    vec3_t big;
    vec3_t negW;
`ifdef INPUT_LOOP_SAT_EN
    expPos = 16'h7FFF;
`else
    expPos = 16'h0300;
`endif
    big  = mk(16'h7F00, 16'h7F00, 16'h7F00);
    negW = mk(16'h8000, 16'h8000, 16'h8000);
    expNeg = model(big, negW, 16'h0000);
    drive(1'b1, big, big, 16'h0000);
    drive(1'b1, big, negW, 16'h0000);
    nChecks++;
    if (fm_o !== expPos) $display("[TB] FAIL overflow_pos: got %h expected %h", fm_o, expPos);
    else nPass++;
    idle();
    nChecks++;
    if (fm_o !== expNeg) $display("[TB] FAIL overflow_neg: got %h expected %h", fm_o, expNeg);
    else nPass++;
    idle();
    expFm = expNeg;
  endtask

  task automatic test_rounding();
    drive(1'b1, mk(16'hFFFF, 16'h0000, 16'h0000), mk(16'h0080, 16'h0000, 16'h0000), 16'h0000);
    idle();
    nChecks++;
    if (valid_o !== 1'b1 || fm_o !== 16'hFFFF)
      $display("[TB] FAIL floor_round: got v=%b fm=%h expected v=1 fm=ffff", valid_o, fm_o);
    else nPass++;
    idle();
    expFm = 16'hFFFF;
  endtask

  task automatic test_back_to_back();
    data_t expQ[$];
    logic  prevV;
    logic  v;
    vec3_t f;
    vec3_t w;
    data_t init;
    prevV = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c < 8) v = 1'b1;
      else if (c < 27) v = 1'($urandom_range(0, 1));
      else v = 1'b0;
      f = randVec();
      w = randVec();
      init = data_t'($urandom);
      if (v) expQ.push_back(model(f, w, init));
      drive(v, f, w, init);
      if (prevV) expFm = expQ.pop_front();
      nChecks++;
      if (valid_o !== prevV)
        $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", c, valid_o, prevV);
      else nPass++;
      nChecks++;
      if (fm_o !== expFm)
        $display("[TB] FAIL stream_fm[%0d]: got %h expected %h", c, fm_o, expFm);
      else nPass++;
      prevV = v;
    end
  endtask

  task automatic test_reset_inflight();
    vec3_t a;
    vec3_t b;
    vec3_t w1;
    data_t expA;
    a  = mk(16'h0100, 16'h0200, 16'h0300);
    b  = mk(16'h0400, 16'h0500, 16'h0600);
    w1 = mk(16'h0100, 16'h0100, 16'h0100);
    expA = model(a, w1, 16'h0000);
    drive(1'b1, a, w1, 16'h0000);
    drive(1'b1, b, w1, 16'h0000);
    nChecks++;
    if (valid_o !== 1'b1 || fm_o !== expA)
      $display("[TB] FAIL inflight_pre: got v=%b fm=%h expected v=1 fm=%h", valid_o, fm_o, expA);
    else nPass++;
    #2 rst_n = 1'b0;
    valid_i = 1'b0;
    #1;
    nChecks++;
    if (valid_o !== 1'b0 || fm_o !== 16'h0000)
      $display("[TB] FAIL async_clear: got v=%b fm=%h expected v=0 fm=0000", valid_o, fm_o);
    else nPass++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      idle();
      nChecks++;
      if (valid_o !== 1'b0 || fm_o !== 16'h0000)
        $display("[TB] FAIL stale_after_reset[%0d]: got v=%b fm=%h expected v=0 fm=0000", c, valid_o, fm_o);
      else nPass++;
    end
    drive(1'b1, b, w1, 16'h0100);
    nChecks++;
    if (valid_o !== 1'b0) $display("[TB] FAIL restart_latency1: got %b expected 0", valid_o);
    else nPass++;
    idle();
    nChecks++;
    if (valid_o !== 1'b1 || fm_o !== model(b, w1, 16'h0100))
      $display("[TB] FAIL restart_value: got v=%b fm=%h expected v=1 fm=%h", valid_o, fm_o, model(b, w1, 16'h0100));
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_and_mixed();
    test_overflow();
    test_rounding();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
